// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready requesters.
// Grants are held for at most MAX_BURST beats; the FIFO side is driven from a registered stage.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BURST  = 4,
   parameter int ID_WIDTH   = 2
) (
   input  logic                          CLK,
   input  logic                          RESET,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          fifo_write,
   output logic [DATA_WIDTH-1:0]         fifo_input_data,
   input  logic                          fifo_full,
   output logic [ID_WIDTH-1:0]           grant_id,
   output logic                          busy
);

   localparam int CNT_W = $clog2(MAX_BURST) + 1;

   typedef enum logic {S_IDLE, S_GRANT} state_e;

   state_e                state_q, state_d;
   logic [ID_WIDTH-1:0]   grant_q, grant_d;
   logic [ID_WIDTH-1:0]   last_q, last_d;
   logic [CNT_W-1:0]      beat_q, beat_d;
   logic                  wr_q, wr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;

   logic                  load, accept;
   logic                  sel_valid, sel_last;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  found_hi, found_lo, arb_found;
   logic [ID_WIDTH-1:0]   idx_hi, idx_lo, arb_idx;

   // The output register may take a new beat when empty or when the FIFO drains it this edge.
   assign load   = !wr_q || !fifo_full;
   assign accept = (state_q == S_GRANT) && sel_valid && load;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q == ID_WIDTH'(i)) begin
            sel_valid    = req_valid[i];
            sel_last     = req_last[i];
            sel_data     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            req_ready[i] = (state_q == S_GRANT) && load;
         end
      end
   end

   // Rotating priority: first valid index above last_q, otherwise first valid at or below it.
   always_comb begin
      found_hi = 1'b0;
      found_lo = 1'b0;
      idx_hi   = '0;
      idx_lo   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_valid[i] && !found_hi && (ID_WIDTH'(i) > last_q)) begin
            found_hi = 1'b1;
            idx_hi   = ID_WIDTH'(i);
         end
         if (req_valid[i] && !found_lo && (ID_WIDTH'(i) <= last_q)) begin
            found_lo = 1'b1;
            idx_lo   = ID_WIDTH'(i);
         end
      end
      arb_found = found_hi || found_lo;
      arb_idx   = found_hi ? idx_hi : idx_lo;
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      beat_d  = beat_q;
      wr_d    = wr_q;
      data_d  = data_q;

      case (state_q)
         S_IDLE: begin
            if (arb_found) begin
               grant_d = arb_idx;
               beat_d  = '0;
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            if (accept && (sel_last || (beat_q == CNT_W'(MAX_BURST - 1)))) begin
               last_d  = grant_q;
               state_d = S_IDLE;
            end else if (accept) begin
               beat_d = beat_q + 1'b1;
            end else if (!sel_valid) begin
               last_d  = grant_q;
               state_d = S_IDLE;
            end
         end
      endcase

      // Data holds while the FIFO is full so the pending write stays stable.
      if (load) begin
         wr_d = accept;
         if (accept) begin
            data_d = sel_data;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         last_q  <= ID_WIDTH'(NUM_REQ - 1);
         beat_q  <= '0;
         wr_q    <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         beat_q  <= beat_d;
         wr_q    <= wr_d;
         data_q  <= data_d;
      end
   end

   assign fifo_write      = wr_q;
   assign fifo_input_data = data_q;
   assign grant_id        = grant_q;
   assign busy            = (state_q == S_GRANT);

endmodule
